// File: rtl/mul_acc_pkg.sv
// Shared definitions for the multiply-accumulate unit.
//   PROD_W  : width of one product beat from the multiplier
//   CNT_W   : width of the per-vector product counter
//   state_t : control states of mul_acc_unit
package mul_acc_pkg;

  localparam int unsigned PROD_W = 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/sat_adder.sv
// Saturating adder: acc + in_prod, clamped to all-ones on carry out.
// Ports:
//   acc     : current accumulator value (ACC_W bits)
//   in_prod : unsigned product to add (PROD_W bits)
//   sum     : saturated result (ACC_W bits)
//   sat     : high when the true sum did not fit in ACC_W bits
module sat_adder
  import mul_acc_pkg::*;
#(
  parameter int unsigned ACC_W = 12
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] in_prod,
  output logic [ACC_W-1:0]  sum,
  output logic              sat
);

  logic [ACC_W:0] wide_sum;

  always_comb begin
    wide_sum = {1'b0, acc} + (ACC_W + 1)'(in_prod);
    sat      = wide_sum[ACC_W];
    sum      = sat ? '1 : wide_sum[ACC_W-1:0];
  end

endmodule

// File: rtl/mul_acc_unit.sv
// Accumulates a vector of unsigned products into a saturating sum and
// presents the result with a valid/ready handshake.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   in_prod   : product beat (PROD_W bits)
//   in_valid  : beat valid; in_last marks the final beat of a vector
//   in_ready  : high while the unit can take a beat (not in HOLD)
//   out_sum   : accumulated sum (ACC_W bits)
//   out_count : products accumulated in the vector
//   out_ovf   : saturation happened somewhere in the vector
//   out_valid : result available (HOLD only); out_ready consumes it
module mul_acc_unit
  import mul_acc_pkg::*;
#(
  parameter int unsigned VEC_LEN = 8,
  parameter int unsigned ACC_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf,
  output logic              out_valid,
  input  logic              out_ready
);

  state_t            state, state_nxt;
  logic [ACC_W-1:0]  acc, acc_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              ovf, ovf_nxt;

  logic [ACC_W-1:0]  add_sum;
  logic              add_sat;
  logic [CNT_W-1:0]  count_inc;
  logic              beat;
  logic              vec_done;

  sat_adder #(
    .ACC_W (ACC_W)
  ) u_sat_adder (
    .acc     (acc),
    .in_prod (in_prod),
    .sum     (add_sum),
    .sat     (add_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      ovf   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      count <= count_nxt;
      ovf   <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    count_nxt = count;
    ovf_nxt   = ovf;
    in_ready  = 1'b1;
    out_valid = 1'b0;
    beat      = in_valid;
    // In IDLE the count is zero, so count_inc also yields the first count.
    count_inc = count + 1'b1;
    vec_done  = in_last || (count_inc == CNT_W'(VEC_LEN));

    unique case (state)
      IDLE: begin
        if (beat) begin
          acc_nxt   = ACC_W'(in_prod);
          count_nxt = count_inc;
          ovf_nxt   = 1'b0;
          state_nxt = vec_done ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_nxt   = add_sum;
          count_nxt = count_inc;
          ovf_nxt   = ovf | add_sat;
          if (vec_done) state_nxt = HOLD;
        end
      end
      HOLD: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
          acc_nxt   = '0;
          count_nxt = '0;
          ovf_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        acc_nxt   = '0;
        count_nxt = '0;
        ovf_nxt   = 1'b0;
      end
    endcase
  end

  assign out_sum   = acc;
  assign out_count = count;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_mul_acc_unit.sv
module tb_mul_acc_unit;
  import mul_acc_pkg::*;

  logic clk = 1'b0;
  logic rst;

  // default-parameter instance
  logic [7:0]  in_prod;
  logic        in_valid, in_last, in_ready;
  logic [11:0] out_sum;
  logic [3:0]  out_count;
  logic        out_ovf, out_valid, out_ready;

  // narrow-accumulator instance
  logic [7:0]  b_in_prod;
  logic        b_in_valid, b_in_last, b_in_ready;
  logic [9:0]  b_out_sum;
  logic [3:0]  b_out_count;
  logic        b_out_ovf, b_out_valid, b_out_ready;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  mul_acc_unit #(.VEC_LEN(8), .ACC_W(12)) dut (
    .clk(clk), .rst(rst), .in_prod(in_prod), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_sum(out_sum),
    .out_count(out_count), .out_ovf(out_ovf), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  mul_acc_unit #(.VEC_LEN(8), .ACC_W(10)) dut_b (
    .clk(clk), .rst(rst), .in_prod(b_in_prod), .in_valid(b_in_valid),
    .in_last(b_in_last), .in_ready(b_in_ready), .out_sum(b_out_sum),
    .out_count(b_out_count), .out_ovf(b_out_ovf), .out_valid(b_out_valid),
    .out_ready(b_out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] p, input logic last);
    in_prod  = p;
    in_valid = 1'b1;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic b_beat(input logic [7:0] p, input logic last);
    b_in_prod  = p;
    b_in_valid = 1'b1;
    b_in_last  = last;
    step();
    b_in_valid = 1'b0;
    b_in_last  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_prod = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    b_in_prod = '0; b_in_valid = 1'b0; b_in_last = 1'b0; b_out_ready = 1'b1;
    #1;

    // Reset held for two cycles
    step();
    step();
    rst = 1'b0;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_sum",   32'(out_sum),   0);
    check("rst_count", 32'(out_count), 0);
    check("rst_ovf",   32'(out_ovf),   0);
    check("rst_ready", 32'(in_ready),  1);

    // 1,4,9,16 with a stray in_last while in_valid is low
    beat(8'd1, 1'b0);
    beat(8'd4, 1'b0);
    in_last = 1'b1;
    step();
    in_last = 1'b0;
    check("gap_valid", 32'(out_valid), 0);
    check("gap_count", 32'(out_count), 2);
    beat(8'd9, 1'b0);
    beat(8'd16, 1'b1);
    check("v1_valid", 32'(out_valid), 1);
    check("v1_sum",   32'(out_sum),   30);
    check("v1_count", 32'(out_count), 4);
    check("v1_ovf",   32'(out_ovf),   0);
    check("v1_ready", 32'(in_ready),  0);
    step();
    check("v1_rel_valid", 32'(out_valid), 0);
    check("v1_rel_sum",   32'(out_sum),   0);
    check("v1_rel_ready", 32'(in_ready),  1);

    // Single-beat vector straight from IDLE
    beat(8'd200, 1'b1);
    check("one_valid", 32'(out_valid), 1);
    check("one_sum",   32'(out_sum),   200);
    check("one_count", 32'(out_count), 1);
    step();

    // 8 beats of 225, auto-terminate at VEC_LEN; consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) beat(8'd225, 1'b0);
    check("v8_pre_valid", 32'(out_valid), 0);
    check("v8_pre_count", 32'(out_count), 7);
    beat(8'd225, 1'b0);
    check("v8_valid", 32'(out_valid), 1);
    check("v8_sum",   32'(out_sum),   1800);
    check("v8_count", 32'(out_count), 8);
    check("v8_ovf",   32'(out_ovf),   0);
    check("v8_ready", 32'(in_ready),  0);

    // HOLD with out_ready low while beats are offered
    in_prod = 8'd50; in_valid = 1'b1; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", 32'(out_valid), 1);
      check("hold_sum",   32'(out_sum),   1800);
      check("hold_count", 32'(out_count), 8);
      check("hold_ready", 32'(in_ready),  0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    step();
    check("hold_rel_valid", 32'(out_valid), 0);
    check("hold_rel_count", 32'(out_count), 0);

    // Narrow accumulator saturates
    for (int i = 0; i < 4; i++) b_beat(8'd225, 1'b0);
    check("sat_pre_sum", 32'(b_out_sum), 900);
    check("sat_pre_ovf", 32'(b_out_ovf), 0);
    b_beat(8'd225, 1'b1);
    check("sat_valid", 32'(b_out_valid), 1);
    check("sat_sum",   32'(b_out_sum),   1023);
    check("sat_ovf",   32'(b_out_ovf),   1);
    check("sat_count", 32'(b_out_count), 5);
    step();
    check("sat_rel_ovf", 32'(b_out_ovf), 0);

    // Reset mid-vector, coincident with an offered beat
    beat(8'd1, 1'b0);
    beat(8'd2, 1'b0);
    beat(8'd3, 1'b0);
    check("mid_sum",   32'(out_sum),   6);
    check("mid_count", 32'(out_count), 3);
    rst = 1'b1; in_prod = 8'd7; in_valid = 1'b1; in_last = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_sum",   32'(out_sum),   0);
    check("mid_rst_count", 32'(out_count), 0);
    beat(8'd2, 1'b0);
    beat(8'd3, 1'b1);
    check("post_valid", 32'(out_valid), 1);
    check("post_sum",   32'(out_sum),   5);
    check("post_count", 32'(out_count), 2);

    // Reset in HOLD discards the pending result despite out_ready
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("hold_rst_valid", 32'(out_valid), 0);
    check("hold_rst_sum",   32'(out_sum),   0);
    check("hold_rst_ready", 32'(in_ready),  1);
    step();
    check("idle_valid", 32'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
